// File: rtl/id_fwd_pkg.sv
// id_fwd_pkg: shared FSM encoding, producer stage indices and saturating add for the ID forwarding unit
package id_fwd_pkg;

   typedef enum logic {RUN, STALL} state_t;

   // Producer stage indices, youngest (highest priority) first
   localparam int EXE = 0;
   localparam int MEM = 1;
   localparam int WB  = 2;

   // Add b to a, clamping the result at max instead of wrapping
   function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b, input logic [63:0] max);
      logic [64:0] s;
      s = {1'b0, a} + {1'b0, b};
      return (s > {1'b0, max}) ? max : s[63:0];
   endfunction

endpackage

// File: rtl/fwd_match.sv
// fwd_match: priority matcher resolving one operand against the in-flight producers
//   ren      : operand is read by the instruction
//   addr     : operand register address (0 never matches)
//   rf_data  : fallback value when no producer matches
//   wena/waddr/wdata/ready : per-producer write enable, destination, result, result-valid
//   hit      : youngest matching producer is ready, data is forwarded
//   blocked  : youngest matching producer is not ready yet
//   data     : forwarded value on hit, rf_data otherwise
module fwd_match #(
   parameter int DW    = 32,
   parameter int AW    = 5,
   parameter int NPROD = 3
) (
   input  logic               ren,
   input  logic [AW-1:0]       addr,
   input  logic [DW-1:0]       rf_data,
   input  logic [NPROD-1:0]    wena,
   input  logic [NPROD*AW-1:0] waddr,
   input  logic [NPROD*DW-1:0] wdata,
   input  logic [NPROD-1:0]    ready,
   output logic               hit,
   output logic               blocked,
   output logic [DW-1:0]       data
);

   logic          found;
   logic          rdy;
   logic [DW-1:0] win;

   // Scan oldest to youngest so the youngest match is the one that sticks;
   // an older ready producer must never override a younger pending one.
   always_comb begin
      found = 1'b0;
      rdy   = 1'b0;
      win   = '0;
      for (int k = NPROD - 1; k >= 0; k--)
         if (ren && wena[k] && addr != '0 && waddr[k*AW +: AW] == addr) begin
            found = 1'b1;
            rdy   = ready[k];
            win   = wdata[k*DW +: DW];
         end
      hit     = found && rdy;
      blocked = found && !rdy;
      data    = hit ? win : rf_data;
   end

endmodule

// File: rtl/id_fwd_unit.sv
// id_fwd_unit: ID-stage operand forwarding, variable-length hazard stall, watchdog and statistics
//   clk, rst (sync, active-low)
//   id_*        : instruction in ID (valid, rs/rt addresses, read enables for rs/rt/HI/LO)
//   rf_*        : register-file / architectural HI/LO values
//   prod_*      : NPROD producer stages, slice k = stage k, k=0 youngest
//   rs_data, rt_data, hi_out, lo_out : registered resolved operands
//   stall       : freeze PC and IF/ID, bubble into EXE
//   fwd_hit     : last update forwarded at least one operand
//   wd_err      : sticky stall watchdog error
//   stat_stall, stat_fwd : saturating stall-cycle and forwarded-operand counters
module id_fwd_unit
   import id_fwd_pkg::*;
#(
   parameter int DW        = 32,
   parameter int AW        = 5,
   parameter int NPROD     = 3,
   parameter int MAX_STALL = 8,
   parameter int CW        = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               id_valid,
   input  logic [AW-1:0]       id_rs,
   input  logic [AW-1:0]       id_rt,
   input  logic               id_rs_ren,
   input  logic               id_rt_ren,
   input  logic               id_hi_ren,
   input  logic               id_lo_ren,
   input  logic [DW-1:0]       rf_rs_data,
   input  logic [DW-1:0]       rf_rt_data,
   input  logic [DW-1:0]       rf_hi_data,
   input  logic [DW-1:0]       rf_lo_data,
   input  logic [NPROD-1:0]    prod_wena,
   input  logic [NPROD*AW-1:0] prod_waddr,
   input  logic [NPROD*DW-1:0] prod_wdata,
   input  logic [NPROD-1:0]    prod_ready,
   input  logic [NPROD-1:0]    prod_hi_wena,
   input  logic [NPROD-1:0]    prod_lo_wena,
   input  logic [NPROD*DW-1:0] prod_hi,
   input  logic [NPROD*DW-1:0] prod_lo,
   output logic [DW-1:0]       rs_data,
   output logic [DW-1:0]       rt_data,
   output logic [DW-1:0]       hi_out,
   output logic [DW-1:0]       lo_out,
   output logic               stall,
   output logic               fwd_hit,
   output logic               wd_err,
   output logic [CW-1:0]       stat_stall,
   output logic [CW-1:0]       stat_fwd
);

   localparam int          SW   = $clog2(MAX_STALL + 1);
   localparam logic [63:0] CMAX = 64'({CW{1'b1}});

   // HI/LO have no address: tie both sides of the compare to the same nonzero value
   localparam logic [AW-1:0]       HL_ADDR  = '1;
   localparam logic [NPROD*AW-1:0] HL_WADDR = '1;

   state_t         state, state_n;
   logic [SW-1:0]  cnt;
   logic           rs_hit, rt_hit, hi_hit, lo_hit;
   logic           rs_blk, rt_blk, hi_blk, lo_blk;
   logic [DW-1:0]  rs_res, rt_res, hi_res, lo_res;
   logic           blk;
   logic [2:0]     nfwd;

   fwd_match #(.DW(DW), .AW(AW), .NPROD(NPROD)) u_rs (
      .ren(id_rs_ren), .addr(id_rs), .rf_data(rf_rs_data),
      .wena(prod_wena), .waddr(prod_waddr), .wdata(prod_wdata), .ready(prod_ready),
      .hit(rs_hit), .blocked(rs_blk), .data(rs_res)
   );

   fwd_match #(.DW(DW), .AW(AW), .NPROD(NPROD)) u_rt (
      .ren(id_rt_ren), .addr(id_rt), .rf_data(rf_rt_data),
      .wena(prod_wena), .waddr(prod_waddr), .wdata(prod_wdata), .ready(prod_ready),
      .hit(rt_hit), .blocked(rt_blk), .data(rt_res)
   );

   fwd_match #(.DW(DW), .AW(AW), .NPROD(NPROD)) u_hi (
      .ren(id_hi_ren), .addr(HL_ADDR), .rf_data(rf_hi_data),
      .wena(prod_hi_wena), .waddr(HL_WADDR), .wdata(prod_hi), .ready(prod_ready),
      .hit(hi_hit), .blocked(hi_blk), .data(hi_res)
   );

   fwd_match #(.DW(DW), .AW(AW), .NPROD(NPROD)) u_lo (
      .ren(id_lo_ren), .addr(HL_ADDR), .rf_data(rf_lo_data),
      .wena(prod_lo_wena), .waddr(HL_WADDR), .wdata(prod_lo), .ready(prod_ready),
      .hit(lo_hit), .blocked(lo_blk), .data(lo_res)
   );

   // Re-resolved every cycle, so the stall lasts exactly as long as a producer needs
   always_comb begin
      blk     = id_valid && (rs_blk || rt_blk || hi_blk || lo_blk);
      nfwd    = 3'(rs_hit) + 3'(rt_hit) + 3'(hi_hit) + 3'(lo_hit);
      state_n = blk ? STALL : RUN;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= RUN;
         cnt        <= '0;
         rs_data    <= '0;
         rt_data    <= '0;
         hi_out     <= '0;
         lo_out     <= '0;
         stall      <= 1'b0;
         fwd_hit    <= 1'b0;
         wd_err     <= 1'b0;
         stat_stall <= '0;
         stat_fwd   <= '0;
      end else begin
         state <= state_n;
         stall <= blk;
         if (blk) begin
            fwd_hit    <= 1'b0;
            stat_stall <= CW'(sat_add(64'(stat_stall), 64'd1, CMAX));
            cnt        <= (state == RUN) ? SW'(1) : SW'(sat_add(64'(cnt), 64'd1, 64'(MAX_STALL)));
            if (state == STALL && cnt == SW'(MAX_STALL))
               wd_err <= 1'b1;
         end else begin
            rs_data  <= rs_res;
            rt_data  <= rt_res;
            hi_out   <= hi_res;
            lo_out   <= lo_res;
            fwd_hit  <= nfwd != 3'd0;
            stat_fwd <= CW'(sat_add(64'(stat_fwd), 64'(nfwd), CMAX));
            cnt      <= '0;
         end
      end
   end

endmodule

// File: tb/tb_id_fwd_unit.sv
// tb_id_fwd_unit: scoreboard bench for id_fwd_unit with a behavioural reference model
module tb_id_fwd_unit;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NP = 3;
   localparam int MS = 8;
   localparam int CW = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             id_valid;
   logic [AW-1:0]    id_rs, id_rt;
   logic             id_rs_ren, id_rt_ren, id_hi_ren, id_lo_ren;
   logic [DW-1:0]    rf_rs_data, rf_rt_data, rf_hi_data, rf_lo_data;
   logic [NP-1:0]    prod_wena, prod_ready, prod_hi_wena, prod_lo_wena;
   logic [NP*AW-1:0] prod_waddr;
   logic [NP*DW-1:0] prod_wdata, prod_hi, prod_lo;
   logic [DW-1:0]    rs_data, rt_data, hi_out, lo_out;
   logic             stall, fwd_hit, wd_err;
   logic [CW-1:0]    stat_stall, stat_fwd;

   always #5 clk = ~clk;

   id_fwd_unit #(.DW(DW), .AW(AW), .NPROD(NP), .MAX_STALL(MS), .CW(CW)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid),
      .id_rs(id_rs), .id_rt(id_rt),
      .id_rs_ren(id_rs_ren), .id_rt_ren(id_rt_ren), .id_hi_ren(id_hi_ren), .id_lo_ren(id_lo_ren),
      .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data), .rf_hi_data(rf_hi_data), .rf_lo_data(rf_lo_data),
      .prod_wena(prod_wena), .prod_waddr(prod_waddr), .prod_wdata(prod_wdata), .prod_ready(prod_ready),
      .prod_hi_wena(prod_hi_wena), .prod_lo_wena(prod_lo_wena), .prod_hi(prod_hi), .prod_lo(prod_lo),
      .rs_data(rs_data), .rt_data(rt_data), .hi_out(hi_out), .lo_out(lo_out),
      .stall(stall), .fwd_hit(fwd_hit), .wd_err(wd_err),
      .stat_stall(stat_stall), .stat_fwd(stat_fwd)
   );

   typedef struct packed {
      logic [DW-1:0] rs, rt, hi, lo;
      logic          st, fh, wd;
      logic [CW-1:0] ss, sf;
   } exp_t;

   exp_t q[$];
   exp_t m;
   int   m_cnt;
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic void res_gpr(input logic ren, input logic [AW-1:0] a, input logic [DW-1:0] rf,
                                   output logic [DW-1:0] v, output bit h, output bit b);
      int k = 0;
      v = rf; h = 0; b = 0;
      if (ren && a != 0) begin
         while (k < NP && !(prod_wena[k] && prod_waddr[k*AW +: AW] == a)) k++;
         if (k < NP) begin
            if (prod_ready[k]) begin h = 1; v = prod_wdata[k*DW +: DW]; end
            else b = 1;
         end
      end
   endfunction

   function automatic void res_hl(input logic ren, input logic [NP-1:0] we, input logic [NP*DW-1:0] vals,
                                  input logic [DW-1:0] rf, output logic [DW-1:0] v, output bit h, output bit b);
      int k = 0;
      v = rf; h = 0; b = 0;
      if (ren) begin
         while (k < NP && !we[k]) k++;
         if (k < NP) begin
            if (prod_ready[k]) begin h = 1; v = vals[k*DW +: DW]; end
            else b = 1;
         end
      end
   endfunction

   // Predict the outputs for the current inputs, clock once, then compare against the oldest prediction
   task automatic step();
      logic [DW-1:0] vrs, vrt, vhi, vlo;
      bit hrs, hrt, hhi, hlo, brs, brt, bhi, blo, blk;
      int n, s;
      exp_t e;
      res_gpr(id_rs_ren, id_rs, rf_rs_data, vrs, hrs, brs);
      res_gpr(id_rt_ren, id_rt, rf_rt_data, vrt, hrt, brt);
      res_hl(id_hi_ren, prod_hi_wena, prod_hi, rf_hi_data, vhi, hhi, bhi);
      res_hl(id_lo_ren, prod_lo_wena, prod_lo, rf_lo_data, vlo, hlo, blo);
      blk = id_valid && (brs || brt || bhi || blo);
      n   = int'(hrs) + int'(hrt) + int'(hhi) + int'(hlo);
      if (!rst) begin
         m = '0;
         m_cnt = 0;
      end else if (blk) begin
         if (!m.st) m_cnt = 1;
         else begin
            if (m_cnt == MS) m.wd = 1;
            if (m_cnt < MS) m_cnt++;
         end
         m.st = 1;
         m.fh = 0;
         if (m.ss != '1) m.ss = m.ss + 1'b1;
      end else begin
         m.rs = vrs; m.rt = vrt; m.hi = vhi; m.lo = vlo;
         m.fh = (n != 0);
         s = int'(m.sf) + n;
         m.sf = (s > 255) ? 8'hFF : 8'(s);
         m.st = 0;
         m_cnt = 0;
      end
      q.push_back(m);
      @(posedge clk);
      #1;
      e = q.pop_front();
      chk("rs_data", 64'(rs_data), 64'(e.rs));
      chk("rt_data", 64'(rt_data), 64'(e.rt));
      chk("hi_out", 64'(hi_out), 64'(e.hi));
      chk("lo_out", 64'(lo_out), 64'(e.lo));
      chk("stall", 64'(stall), 64'(e.st));
      chk("fwd_hit", 64'(fwd_hit), 64'(e.fh));
      chk("wd_err", 64'(wd_err), 64'(e.wd));
      chk("stat_stall", 64'(stat_stall), 64'(e.ss));
      chk("stat_fwd", 64'(stat_fwd), 64'(e.sf));
   endtask

   task automatic set_prod(input int k, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic r);
      prod_wena[k] = we;
      prod_waddr[k*AW +: AW] = a;
      prod_wdata[k*DW +: DW] = d;
      prod_ready[k] = r;
   endtask

   task automatic set_hl(input int k, input logic hwe, input logic [DW-1:0] hv, input logic lwe, input logic [DW-1:0] lv);
      prod_hi_wena[k] = hwe;
      prod_hi[k*DW +: DW] = hv;
      prod_lo_wena[k] = lwe;
      prod_lo[k*DW +: DW] = lv;
   endtask

   task automatic clear_all();
      prod_wena = '0; prod_waddr = '0; prod_wdata = '0; prod_ready = '0;
      prod_hi_wena = '0; prod_lo_wena = '0; prod_hi = '0; prod_lo = '0;
      id_rs_ren = 0; id_rt_ren = 0; id_hi_ren = 0; id_lo_ren = 0;
      id_rs = '0; id_rt = '0;
   endtask

   task automatic do_reset();
      rst = 0;
      step();
      step();
      rst = 1;
   endtask

   initial begin
      rst = 0;
      id_valid = 1;
      rf_rs_data = 32'hAAAA; rf_rt_data = 32'hBBBB; rf_hi_data = 32'hC0C0; rf_lo_data = 32'hD0D0;
      clear_all();
      do_reset();
      chk("reset_rs", 64'(rs_data), 64'h0);
      chk("reset_stall", 64'(stall), 64'h0);

      // youngest of two ready producers wins
      set_prod(0, 1, 5, 32'h11, 1);
      set_prod(1, 1, 5, 32'h22, 1);
      id_rs = 5; id_rs_ren = 1;
      step();
      chk("prio_rs", 64'(rs_data), 64'h11);
      chk("prio_hit", 64'(fwd_hit), 64'h1);
      chk("prio_stat", 64'(stat_fwd), 64'h1);

      // load-use: one stall cycle, then forwarded from MEM
      clear_all();
      id_rt = 7; id_rt_ren = 1;
      set_prod(0, 1, 7, 32'h0, 0);
      step();
      chk("load_stall", 64'(stall), 64'h1);
      set_prod(0, 0, 0, 32'h0, 0);
      set_prod(1, 1, 7, 32'hCAFE, 1);
      step();
      chk("load_rt", 64'(rt_data), 64'hCAFE);
      chk("load_unstall", 64'(stall), 64'h0);
      chk("load_stat", 64'(stat_stall), 64'h1);

      // r0 never forwards
      clear_all();
      rf_rs_data = 32'h5555;
      id_rs = 0; id_rs_ren = 1;
      set_prod(0, 1, 0, 32'hFF, 1);
      step();
      chk("r0_rs", 64'(rs_data), 64'h5555);
      chk("r0_hit", 64'(fwd_hit), 64'h0);

      // younger not-ready must block even if older stage is ready
      clear_all();
      id_rs = 9; id_rs_ren = 1;
      set_prod(0, 1, 9, 32'h1, 0);
      set_prod(1, 1, 9, 32'h2, 1);
      step();
      chk("older_block", 64'(stall), 64'h1);
      set_prod(0, 1, 9, 32'h1, 1);
      step();
      chk("older_rs", 64'(rs_data), 64'h1);

      // rs and rt blocked by different stages
      clear_all();
      id_rs = 4; id_rs_ren = 1; id_rt = 6; id_rt_ren = 1;
      set_prod(0, 1, 4, 32'h44, 0);
      set_prod(1, 1, 6, 32'h66, 0);
      step();
      set_prod(0, 1, 4, 32'h44, 1);
      step();
      chk("dual_hold", 64'(stall), 64'h1);
      set_prod(1, 1, 6, 32'h66, 1);
      step();
      chk("dual_rs", 64'(rs_data), 64'h44);
      chk("dual_rt", 64'(rt_data), 64'h66);

      // invalid instruction never stalls
      id_valid = 0;
      set_prod(0, 1, 4, 32'h44, 0);
      step();
      chk("inval_stall", 64'(stall), 64'h0);
      id_valid = 1;

      // watchdog
      clear_all();
      id_rs = 3; id_rs_ren = 1;
      set_prod(0, 1, 3, 32'h33, 0);
      for (int i = 1; i <= 10; i++) begin
         step();
         if (i == 8) chk("wd_before", 64'(wd_err), 64'h0);
         if (i == 9) chk("wd_set", 64'(wd_err), 64'h1);
      end
      chk("wd_sticky", 64'(wd_err), 64'h1);
      chk("wd_stall", 64'(stall), 64'h1);
      clear_all();
      do_reset();
      chk("rst_wd", 64'(wd_err), 64'h0);
      chk("rst_ss", 64'(stat_stall), 64'h0);

      // HI from MEM when EXE does not write HI; LO blocked by EXE
      set_hl(0, 0, 32'h7, 1, 32'h70);
      set_hl(1, 1, 32'h1234, 0, 32'h0);
      set_hl(2, 1, 32'h9, 0, 32'h0);
      prod_ready = 3'b110;
      id_hi_ren = 1;
      step();
      chk("mfhi", 64'(hi_out), 64'h1234);
      id_hi_ren = 0; id_lo_ren = 1;
      step();
      chk("mflo_block", 64'(stall), 64'h1);
      prod_ready = 3'b111;
      step();
      chk("mflo", 64'(lo_out), 64'h70);

      // random traffic against the model
      for (int i = 0; i < 200; i++) begin
         id_valid = ($urandom_range(0, 7) != 0);
         id_rs = AW'($urandom_range(0, 3)); id_rt = AW'($urandom_range(0, 3));
         id_rs_ren = 1'($urandom); id_rt_ren = 1'($urandom);
         id_hi_ren = 1'($urandom); id_lo_ren = 1'($urandom);
         rf_rs_data = $urandom; rf_rt_data = $urandom; rf_hi_data = $urandom; rf_lo_data = $urandom;
         for (int k = 0; k < NP; k++) begin
            set_prod(k, 1'($urandom), AW'($urandom_range(0, 3)), $urandom, ($urandom_range(0, 3) != 0));
            set_hl(k, 1'($urandom), $urandom, 1'($urandom), $urandom);
         end
         step();
      end

      // stat_fwd saturation: four forwards per cycle
      clear_all();
      id_valid = 1;
      do_reset();
      id_rs = 1; id_rs_ren = 1; id_rt = 2; id_rt_ren = 1; id_hi_ren = 1; id_lo_ren = 1;
      set_prod(0, 1, 1, 32'hA1, 1);
      set_prod(1, 1, 2, 32'hB2, 1);
      set_hl(0, 1, 32'hC3, 1, 32'hD4);
      for (int i = 0; i < 70; i++) step();
      chk("sat_fwd", 64'(stat_fwd), 64'hFF);
      step();
      chk("sat_nowrap", 64'(stat_fwd), 64'hFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/id_fwd_unit.md
Name: id_fwd_unit

Overview:
- Parametrised operand-forwarding and hazard unit for the ID stage of the dynamic pipeline.
- Resolves the rs, rt, HI and LO operands of the instruction in ID against NPROD in-flight producer stages, ordered youngest first (EXE, MEM, WB, ...).
- Stalls ID for as many cycles as a not-yet-ready producer requires, instead of a fixed one-cycle load stall.
- Adds a stall watchdog and saturating hazard statistics counters.

Parameters:
DW, 32, operand/data width
AW, 5, register address width
NPROD, 3, number of producer stages; index 0 = youngest (EXE) = highest priority
MAX_STALL, 8, stall cycles after which the watchdog error sets
CW, 32, statistics counter width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
id_valid  in  1  ID holds a valid instruction
id_rs  in  AW  rs address
id_rt  in  AW  rt address
id_rs_ren  in  1  instruction reads rs
id_rt_ren  in  1  instruction reads rt
id_hi_ren  in  1  instruction reads HI (MFHI)
id_lo_ren  in  1  instruction reads LO (MFLO)
rf_rs_data  in  DW  register-file rs value
rf_rt_data  in  DW  register-file rt value
rf_hi_data  in  DW  architectural HI
rf_lo_data  in  DW  architectural LO
prod_wena  in  NPROD  producer writes the GPR file
prod_waddr  in  NPROD*AW  producer destination, slice k = stage k
prod_wdata  in  NPROD*DW  producer result
prod_ready  in  NPROD  result valid this cycle (0 for a load still in EXE, for example)
prod_hi_wena  in  NPROD  producer writes HI
prod_lo_wena  in  NPROD  producer writes LO
prod_hi  in  NPROD*DW  producer HI value
prod_lo  in  NPROD*DW  producer LO value
rs_data  out  DW  resolved rs operand
rt_data  out  DW  resolved rt operand
hi_out  out  DW  resolved HI
lo_out  out  DW  resolved LO
stall  out  1  freeze PC and IF/ID; insert a bubble into EXE
fwd_hit  out  1  at least one operand was forwarded
wd_err  out  1  sticky: watchdog expired
stat_stall  out  CW  total stall cycles, saturating
stat_fwd  out  CW  total forwarded operands, saturating

Behaviour:
- All outputs are registered on posedge clk. Resolved values appear one cycle after the inputs are sampled.
- Reset (rst=0 at posedge): all outputs = 0; FSM = RUN; stall counter = 0.
- GPR match for operand X (rs or rt):
  - Match at stage k requires: X_ren=1, prod_wena[k]=1, prod_waddr[k]==X, and X != 0.
  - The lowest k wins. Register 0 never forwards and never stalls.
- HI and LO follow the same rule using prod_hi_wena / prod_lo_wena. No address compare.
- Operand resolution:
  - Winning stage ready → take its data, count it as a forward.
  - No match → take the register-file value.
  - Winning stage not ready → operand is blocked. An older stage that is ready must NOT be used instead.
- When id_valid=0, nothing is blocked, stall=0, and operand outputs still update.
- FSM:
  - RUN: if any operand is blocked → STALL, stall<=1, counter<=1. Otherwise stall<=0.
  - STALL: re-resolve all operands every cycle, because producers keep advancing during the stall.
    - When none is blocked → RUN, stall<=0, and the outputs take the newly resolved values on that same edge.
    - Otherwise counter increments and saturates at MAX_STALL.
    - When counter==MAX_STALL, wd_err<=1. Stall continues.
- wd_err clears only on reset.
- fwd_hit = 1 on the edge where outputs update with at least one forwarded operand.
- Statistics:
  - stat_stall += 1 on each cycle that stall is registered as 1.
  - stat_fwd += the number of operands forwarded (0..4) on each non-blocked update.
  - Both saturate at all-ones and do not wrap.
- Simultaneous events: rs and rt may be blocked by different stages. Stall holds until both are resolved.
- A reset during STALL returns to RUN the same edge.

Decomposition:
- Package id_fwd_pkg holds:
  - FSM state encoding (RUN, STALL);
  - the producer index constants EXE=0, MEM=1, WB=2;
  - the saturating-increment function.
- One natural sub-module, fwd_match. It is combinational, instantiated four times (rs, rt, hi, lo), and is a priority matcher returning {hit, blocked, data}. The FSM, watchdog and counters live in the top.

Test Plan:
- EXE writes r5=0x11, MEM writes r5=0x22, both ready, id_rs=5 → rs_data=0x11 next cycle, fwd_hit=1, stall=0, stat_fwd=1.
- Load to r7 in EXE (ready=0); one cycle later it is in MEM (ready=1, data 0xCAFE); id_rt=7 → stall=1 for exactly 1 cycle, then rt_data=0xCAFE, stat_stall=1.
- id_rs=0 with EXE writing r0=0xFF → rs_data=rf_rs_data, no stall, fwd_hit=0.
- Hold EXE r3 not-ready for 10 cycles with MAX_STALL=8 → stall stays 1, wd_err=1 after the 8th stall cycle and remains set; reset clears all outputs.
- MFHI with EXE hi_wena=0, MEM hi_wena=1 (0x1234), WB hi_wena=1 (0x9) → hi_out=0x1234.
- Preload stat_fwd near all-ones via forced forwards → the counter saturates at 0xFFFFFFFF and does not wrap.
